// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 decryption controller.
package aes_dec_pkg;

  localparam int NR        = 10;
  localparam int KEY_IDX_W = 4;
  localparam int BLOCK_W   = 128;
  localparam int BYTE_W    = 8;
  localparam int N_ROWS    = 4;
  localparam int N_COLS    = 4;
  localparam int N_BYTES   = BLOCK_W / BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } dec_fsm_e;

  // Bit offset of byte idx in an ascending [0:127] block (byte 0 is bits [0:7]).
  function automatic int byte_lsb(input int idx);
    return idx * BYTE_W;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_sbox_byte(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // Circulant InvMixColumns row coefficients {0e, 0b, 0d, 09}.
  function automatic logic [7:0] inv_mix_coef(input int k);
    case (k)
      0:       return 8'h0e;
      1:       return 8'h0b;
      2:       return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and
// (unless last) InvMixColumns, built from the inverse-transform primitives below.
module aes_inv_shift_rows
  import aes_dec_pkg::*;
(
  input  logic [0:BLOCK_W-1] din,
  output logic [0:BLOCK_W-1] dout
);
  always_comb begin
    dout = '0;
    for (int c = 0; c < N_COLS; c++) begin
      for (int r = 0; r < N_ROWS; r++) begin
        dout[byte_lsb(r + N_ROWS * c) +: BYTE_W] =
          din[byte_lsb(r + N_ROWS * ((c - r + N_COLS) % N_COLS)) +: BYTE_W];
      end
    end
  end
endmodule

module aes_inv_sub_bytes
  import aes_dec_pkg::*;
(
  input  logic [0:BLOCK_W-1] din,
  output logic [0:BLOCK_W-1] dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      dout[byte_lsb(i) +: BYTE_W] = inv_sbox_byte(din[byte_lsb(i) +: BYTE_W]);
    end
  end
endmodule

module aes_inv_mix_columns
  import aes_dec_pkg::*;
(
  input  logic [0:BLOCK_W-1] din,
  output logic [0:BLOCK_W-1] dout
);
  always_comb begin
    logic [7:0] acc;
    acc  = '0;
    dout = '0;
    for (int c = 0; c < N_COLS; c++) begin
      for (int r = 0; r < N_ROWS; r++) begin
        acc = '0;
        for (int j = 0; j < N_ROWS; j++) begin
          acc = acc ^ gf_mul(inv_mix_coef((j - r + N_ROWS) % N_ROWS),
                             din[byte_lsb(j + N_ROWS * c) +: BYTE_W]);
        end
        dout[byte_lsb(r + N_ROWS * c) +: BYTE_W] = acc;
      end
    end
  end
endmodule

module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [0:BLOCK_W-1] state,
  input  logic [0:BLOCK_W-1] round_key,
  input  logic               last,
  output logic [0:BLOCK_W-1] result
);
  logic [0:BLOCK_W-1] shifted;
  logic [0:BLOCK_W-1] substituted;
  logic [0:BLOCK_W-1] keyed;
  logic [0:BLOCK_W-1] mixed;

  aes_inv_shift_rows  u_shift (.din(state),       .dout(shifted));
  aes_inv_sub_bytes   u_sub   (.din(shifted),     .dout(substituted));
  aes_inv_mix_columns u_mix   (.din(keyed),       .dout(mixed));

  assign keyed  = substituted ^ round_key;
  assign result = last ? keyed : mixed;
endmodule

// File: rtl/aes_dec_iter_ctrl.sv
// Iterative AES-128 decryption controller: one inverse round per cycle, keys fetched by index.
// Optional AES_DEC_ABORT_EN adds an abort input that drops the in-flight block.
module aes_dec_iter_ctrl
  import aes_dec_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:BLOCK_W-1]   ciphertext,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  logic [0:BLOCK_W-1]   round_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:BLOCK_W-1]   plaintext,
  output logic                 busy
`ifdef AES_DEC_ABORT_EN
 ,input  logic                 abort
`endif
);

  dec_fsm_e               fsm_q, fsm_d;
  logic [KEY_IDX_W-1:0]   rnd_q, rnd_d;
  logic [0:BLOCK_W-1]     state_q, state_d;
  logic [0:BLOCK_W-1]     round_out;

  aes_inv_round u_round (
    .state     (state_q),
    .round_key (round_key),
    .last      (fsm_q == ST_FINAL),
    .result    (round_out)
  );

  always_comb begin
    fsm_d     = fsm_q;
    rnd_d     = rnd_q;
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    key_idx   = KEY_IDX_W'(NR);
    case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ciphertext ^ round_key;
          rnd_d   = KEY_IDX_W'(NR - 1);
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        key_idx = rnd_q;
        state_d = round_out;
        if (rnd_q == KEY_IDX_W'(1)) begin
          rnd_d = '0;
          fsm_d = ST_FINAL;
        end else begin
          rnd_d = rnd_q - KEY_IDX_W'(1);
        end
      end
      ST_FINAL: begin
        key_idx = '0;
        state_d = round_out;
        fsm_d   = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
`ifdef AES_DEC_ABORT_EN
    // Abort wins over any completing handshake and leaves no stale plaintext behind.
    if (abort && fsm_q != ST_IDLE) begin
      fsm_d   = ST_IDLE;
      rnd_d   = '0;
      state_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= ST_IDLE;
      rnd_q   <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

  assign plaintext = state_q;
  assign busy      = (fsm_q != ST_IDLE);

endmodule

// File: doc/aes_dec_iter_ctrl.md
# aes_dec_iter_ctrl

Iterative AES-128 decryption controller. It accepts one 128-bit ciphertext block over a valid/ready handshake and sequences the inverse-round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) over 11 key applications. It addresses an external round-key store by index and returns the plaintext over a second valid/ready handshake. It sits between the block-input interface and the existing combinational inverse-round primitives, and is the only user of them.

## Interface
- NR, 10, number of rounds; only 10 is supported.
- KEY_IDX_W, 4, width of the round-key index.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  ciphertext valid.
- in_ready  out  1  controller can accept a block.
- ciphertext  in  [0:127]  input block; byte 0 is bits [0:7]; column-major state.
- key_idx  out  KEY_IDX_W  round-key index requested, 0..10.
- round_key  in  [0:127]  key for key_idx; combinational read, valid in the same cycle.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  sink accepts plaintext.
- plaintext  out  [0:127]  result; equals the state register.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states are IDLE, ROUND, FINAL and DONE. A 4-bit round counter `rnd` drives key_idx.
- **IDLE**
  - in_ready=1, key_idx=10.
  - On in_valid&&in_ready: state <= ciphertext ^ round_key (the initial AddRoundKey with k10), rnd <= 9, go to ROUND.
- **ROUND**
  - key_idx=rnd.
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key).
  - If rnd==1, go to FINAL with rnd <= 0. Otherwise rnd <= rnd-1.
- **FINAL**
  - key_idx=0.
  - state <= InvSubBytes(InvShiftRows(state)) ^ round_key.
  - Go to DONE.
- **DONE**
  - out_valid=1, and plaintext is held stable while waiting.
  - On out_ready: go to IDLE.
- In IDLE, ciphertext and round_key are ignored unless in_valid is high.
- in_ready is low in ROUND, FINAL and DONE. in_valid asserted in those states is not consumed. The source must hold in_valid and the data until it sees in_ready.
- Simultaneous events in DONE: with out_ready=1 and in_valid=1, the output is consumed this cycle. The new input is accepted on the next cycle in IDLE; there is no same-cycle turnaround.
- out_valid must not drop until the transfer completes. plaintext is only meaningful while out_valid=1.
- key_idx outside 0..10 is never driven.
- Reset mid-operation: the in-flight block is discarded with no output produced.

## Timing
- Reset values:
  - state register = 0, rnd = 0, FSM = IDLE.
  - in_ready=1, out_valid=0, busy=0, key_idx=10, plaintext=0.
- Latency:
  - An accept on edge E gives 9 ROUND edges (E+1..E+9) and a FINAL edge at E+10.
  - out_valid is high from after edge E+10.
- Throughput: at most one block per 12 cycles when out_ready is held high (accept, 9 rounds, final, DONE cycle; the accept happens back in IDLE).
- key_idx is a registered-state decode; round_key must settle within the same cycle.

## Configuration
- AES_DEC_ABORT_EN defined:
  - Adds input port `abort` (1 bit).
  - abort=1 in ROUND, FINAL or DONE returns the FSM to IDLE on the next edge, with out_valid=0 and rnd=0. The state register is cleared to 0.
  - abort is ignored in IDLE, and abort has priority over out_ready.
- AES_DEC_ABORT_EN undefined: the `abort` port does not exist, and a block always runs to completion unless reset is asserted.

## Structure
- Shared package `aes_dec_pkg`:
  - FSM state encoding.
  - Constants NR=10, KEY_IDX_W=4, BLOCK_W=128.
  - Byte-slice helper constants.
- One sub-module `aes_inv_round`, purely combinational.
  - Inputs: state, round_key, last (skip InvMixColumns).
  - It instantiates the existing inverse ShiftRows, SubBytes and MixColumns primitives.
  - The controller holds all sequential logic.

## Test plan
- FIPS-197 C.1:
  - Key store loaded with the expansion of 000102030405060708090a0b0c0d0e0f.
  - Stimulus: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: plaintext 00112233445566778899aabbccddeeff with out_valid exactly 10 edges after accept.
- Key sequencing: check that key_idx goes 10, 9, 8, …, 1, 0 on consecutive cycles, and then holds 10 in IDLE.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE; plaintext stays stable and in_ready=0.
  - A second block presented meanwhile is accepted only in the cycle after out_ready=1.
- Back-to-back:
  - Two FIPS blocks with in_valid and out_ready held high.
  - Both produce correct results, with the second accept exactly 12 cycles after the first.
- Reset mid-round:
  - Assert reset at round 5.
  - Outputs immediately take their reset values, and no out_valid appears.
  - The next block decrypts correctly.
- With AES_DEC_ABORT_EN:
  - Pulse abort at round 3; FSM is in IDLE next cycle with out_valid=0.
  - A subsequent C.1 block still gives 00112233445566778899aabbccddeeff.
